aes_key_sched_ctrl: RTL and testbench
=====================================

# aes_key_sched_ctrl

Iterative AES-128 key-schedule controller. Accepts a 128-bit cipher key through a start/ready handshake and expands it one round key per clock into an internal 11 × 128-bit round-key store. It then serves any round key through a registered random-access read port. It replaces the flat combinational expansion in the round pipeline wherever area matters: the cipher/decipher round engine requests keys by index, in forward order for encryption and reverse order for decryption.

## Interface
Parameters:
- NR, 10, number of rounds; round-key store holds NR+1 entries (only 10 is supported)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  load request; accepted when start && start_ready
- key  in  128  cipher key, sampled on the accept cycle; byte 0 = key[127:120]
- start_ready  out  1  high in IDLE and READY, low in EXPAND
- busy  out  1  high while in EXPAND
- done  out  1  one-cycle pulse on entry to READY
- key_valid  out  1  round-key store holds a complete schedule
- rd_en  in  1  read request
- rd_idx  in  4  round index 0..10
- rd_data  out  128  round key rd_idx, registered
- rd_valid  out  1  rd_data valid this cycle

## Operation
- State machine: IDLE -> EXPAND on an accepted start. EXPAND -> READY when round counter = 10 is written. READY -> EXPAND on an accepted start. Any state -> IDLE on rst.
- On accept, write rk[0] = key, set round counter rc = 1, set rcon = 8'h01, and drop key_valid.
- Each EXPAND cycle computes rk[rc] from rk[rc-1] = {w0,w1,w2,w3}:
  - t = SubWord(RotWord(w3)) ^ {rcon,24'h0}
  - n0 = w0^t, n1 = w1^n0, n2 = w2^n1, n3 = w3^n2
  - Write rk[rc] = {n0,n1,n2,n3}, then rc++.
  - Next rcon = xtime(rcon): left shift, XOR 8'h1b if the MSB was set. Sequence: 01,02,04,08,10,20,40,80,1b,36.
- SubWord uses four instances of the shared combinational byte S-box. RotWord is {w3[23:0],w3[31:24]}.
- Only one write per cycle. rk[rc-1] is read from a dedicated "previous key" register, not the store, so the store needs one write port plus one read port.
- Read port:
  - When rd_en && key_valid && rd_idx <= 10: rd_data <= rk[rd_idx] and rd_valid <= 1.
  - Otherwise rd_valid <= 0 and rd_data <= 0, including rd_idx 11..15 and reads during EXPAND.
- start while in EXPAND is ignored (start_ready = 0). Exactly one expansion is in flight.
- start in READY restarts expansion. key_valid falls the cycle after accept, and old contents are not guaranteed readable from that cycle.

## Timing
- Reset values:
  - state = IDLE, rc = 0, rcon = 8'h01
  - start_ready = 1; busy = 0; done = 0; key_valid = 0; rd_valid = 0; rd_data = 0
  - Store contents are don't-care.
- Expansion, with start accepted in cycle T:
  - rk[0] written at the T edge.
  - busy high in cycles T+1..T+10; rk[k] written at the end of cycle T+k.
  - In cycle T+11: state READY, done = 1 for that cycle only, key_valid = 1, start_ready = 1.
  - Total latency from accept to key_valid is 11 cycles.
- Read latency is 1 cycle: rd_en in cycle R gives rd_data/rd_valid in R+1. Back-to-back reads sustain 1 per cycle.
- rd_en in the same cycle as an accepted restart in READY is served from the old schedule. Reads one cycle later return rd_valid = 0.
- rst asserted mid-EXPAND returns to IDLE on the next edge: busy = 0, no done pulse, key_valid = 0. A new start is accepted immediately after rst deasserts.
- start and rst high together: rst wins.

## Test plan
- Reset, then key = 0 and start.
  - Required: busy for 10 cycles, then done pulse and key_valid.
  - Reads return rk0 = 0, rk1 = 62636363626363636263636362636363, rk2 = 9b9898c9f9fbfbaa9b9898c9f9fbfbaa, rk10 = b4ef5bcb3e92e21123e951cf6f8f188e.
- From READY, restart with key = 2b7e151628aed2a6abf7158809cf4f3c.
  - Required: key_valid drops next cycle and returns after 11 cycles.
  - rk1 = a0fafe1788542cb123a339392a6c7605, rk9 = ac7766f319fadc2128d12941575c006e, rk10 = d014f9a8c9ee2589e13f0cc8b6630ca6.
- Reverse-order burst of rd_idx 10..0 on consecutive cycles.
  - Required: 11 consecutive rd_valid cycles with the matching keys, each 1 cycle after its request.
- rd_idx = 11 and 15 in READY, and any rd_idx during EXPAND -> rd_valid = 0, rd_data = 0.
- start pulsed during EXPAND cycle T+4 -> ignored. done still occurs at T+11 and the schedule matches the original key.
- rst asserted at T+5, then a new start -> no done pulse from the aborted run, and the new run's rk10 is correct.

Source files
------------

// File: rtl/aes_key_sched_ctrl.sv
// aes_key_sched_ctrl
//   Iterative AES-128 key-schedule controller. A cipher key accepted via
//   start/start_ready is expanded one round key per clock into an 11-entry
//   round-key store. Once complete, any round key can be read through a
//   registered random-access port (1-cycle latency).
//
// Ports
//   clk          clock, all state updates on rising edge
//   rst          synchronous active-high reset
//   start        load request, accepted when start && start_ready
//   key[127:0]   cipher key, byte 0 = key[127:120]
//   start_ready  high in IDLE and READY
//   busy         high while expanding
//   done         one-cycle pulse on entry to READY
//   key_valid    store holds a complete schedule
//   rd_en        read request
//   rd_idx[3:0]  round index 0..10
//   rd_data      registered round key
//   rd_valid     rd_data valid this cycle
//
// aes_sbox is the shared combinational byte S-box; four copies form SubWord.

module aes_sbox (
  input  logic [7:0] a,
  output logic [7:0] y
);
  localparam logic [2047:0] SBOX_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  // Entry 0 sits in the most significant byte of the table.
  logic [10:0] msb;
  assign msb = 11'd2047 - {a, 3'b000};
  assign y   = SBOX_TABLE[msb -: 8];
endmodule

// state  | meaning
// IDLE   | no schedule loaded, waiting for start
// EXPAND | computing rk[rc] from the previous-key register, one per cycle
// READY  | schedule complete and readable; start restarts expansion
module aes_key_sched_ctrl #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [127:0] key,
  output logic         start_ready,
  output logic         busy,
  output logic         done,
  output logic         key_valid,
  input  logic         rd_en,
  input  logic [3:0]   rd_idx,
  output logic [127:0] rd_data,
  output logic         rd_valid
);
  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_t;

  localparam logic [3:0] LAST = 4'(NR);

  state_t       state_q, state_d;
  logic [3:0]   rc_q;
  logic [7:0]   rcon_q;
  logic [127:0] prev_q;
  logic [127:0] rk_mem [NR+1];
  logic         accept;

  logic [31:0]  w0, w1, w2, w3, rot, sub, t;
  logic [31:0]  n0, n1, n2, n3;
  logic [127:0] next_rk;

  assign accept = start && start_ready;

  // state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXPAND;
      EXPAND:  if (rc_q == LAST) state_d = READY;
      READY:   if (accept) state_d = EXPAND;
      default: state_d = IDLE;
    endcase
  end

  // output logic
  always_comb begin
    start_ready = (state_q != EXPAND);
    busy        = (state_q == EXPAND);
  end

  // round function on the previous round key
  assign {w0, w1, w2, w3} = prev_q;
  assign rot = {w3[23:0], w3[31:24]};

  aes_sbox u_sbox0 (.a(rot[31:24]), .y(sub[31:24]));
  aes_sbox u_sbox1 (.a(rot[23:16]), .y(sub[23:16]));
  aes_sbox u_sbox2 (.a(rot[15:8]),  .y(sub[15:8]));
  aes_sbox u_sbox3 (.a(rot[7:0]),   .y(sub[7:0]));

  assign t       = sub ^ {rcon_q, 24'h0};
  assign n0      = w0 ^ t;
  assign n1      = w1 ^ n0;
  assign n2      = w2 ^ n1;
  assign n3      = w3 ^ n2;
  assign next_rk = {n0, n1, n2, n3};

  // counters, previous key, status flags
  always_ff @(posedge clk) begin
    if (rst) begin
      rc_q      <= 4'd0;
      rcon_q    <= 8'h01;
      key_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        prev_q    <= key;
        rc_q      <= 4'd1;
        rcon_q    <= 8'h01;
        key_valid <= 1'b0;
      end else if (state_q == EXPAND) begin
        prev_q <= next_rk;
        rc_q   <= rc_q + 4'd1;
        rcon_q <= {rcon_q[6:0], 1'b0} ^ (rcon_q[7] ? 8'h1b : 8'h00);
        if (rc_q == LAST) begin
          key_valid <= 1'b1;
          done      <= 1'b1;
        end
      end
    end
  end

  // single write port: rk[0] on accept, rk[rc] while expanding
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (accept)                 rk_mem[0]    <= key;
      else if (state_q == EXPAND) rk_mem[rc_q] <= next_rk;
    end
  end

  // registered read port; a read in the restart cycle still sees the old entry
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (rd_en && key_valid && rd_idx <= LAST) begin
      rd_valid <= 1'b1;
      rd_data  <= rk_mem[rd_idx];
    end else begin
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end
  end
endmodule

// File: tb/tb_aes_key_sched_ctrl.sv
// Directed bench for aes_key_sched_ctrl: expansion timing, known-answer
// round keys, read port behaviour, restart, abort and reset priority.
module tb_aes_key_sched_ctrl;
  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [127:0] key;
  logic         start_ready, busy, done, key_valid;
  logic         rd_en;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic         rd_valid;

  int n_cmp = 0;
  int n_err = 0;

  logic [127:0] zero_rk [11];
  logic [127:0] fips_rk [11];

  aes_key_sched_ctrl #(.NR(10)) dut (
    .clk(clk), .rst(rst), .start(start), .key(key),
    .start_ready(start_ready), .busy(busy), .done(done), .key_valid(key_valid),
    .rd_en(rd_en), .rd_idx(rd_idx), .rd_data(rd_data), .rd_valid(rd_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_chk(input logic [3:0] idx, input logic [127:0] exp, input string tag);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
    check_eq($sformatf("%s_valid", tag), 128'(rd_valid), 128'(1));
    check_eq($sformatf("%s_data", tag), rd_data, exp);
  endtask

  task automatic read_bad(input logic [3:0] idx, input string tag);
    rd_en  = 1'b1;
    rd_idx = idx;
    tick();
    rd_en  = 1'b0;
    check_eq($sformatf("%s_valid", tag), 128'(rd_valid), 128'(0));
    check_eq($sformatf("%s_data", tag), rd_data, 128'(0));
  endtask

  // Accepts k in the current cycle and watches cycles T+1..T+15.
  task automatic run_expand(input logic [127:0] k, input bit rd_on_accept,
                            input logic [127:0] old_rk10, input bit rd_during,
                            input bit start_during, input logic [127:0] decoy,
                            input string tag);
    int busy_cnt, done_cnt, done_cyc, kv_cyc;
    busy_cnt = 0; done_cnt = 0; done_cyc = 0; kv_cyc = 0;
    key    = k;
    start  = 1'b1;
    rd_en  = rd_on_accept;
    rd_idx = 4'd10;
    tick();
    start = 1'b0;
    rd_en = 1'b0;
    for (int c = 1; c <= 15; c++) begin
      if (busy) busy_cnt++;
      if (done) begin
        done_cnt++;
        if (done_cyc == 0) done_cyc = c;
      end
      if (key_valid && kv_cyc == 0) kv_cyc = c;
      if (c == 1) begin
        check_eq($sformatf("%s_kv_drop", tag), 128'(key_valid), 128'(0));
        check_eq($sformatf("%s_sr_low", tag), 128'(start_ready), 128'(0));
      end
      if (c == 1 && rd_on_accept) begin
        check_eq($sformatf("%s_oldrd_valid", tag), 128'(rd_valid), 128'(1));
        check_eq($sformatf("%s_oldrd_data", tag), rd_data, old_rk10);
      end
      if (rd_during && c >= 2 && c <= 10) begin
        check_eq($sformatf("%s_exprd%0d_valid", tag, c), 128'(rd_valid), 128'(0));
        check_eq($sformatf("%s_exprd%0d_data", tag, c), rd_data, 128'(0));
      end
      rd_en  = rd_during && (c <= 9);
      rd_idx = 4'(c);
      start  = start_during && (c == 4);
      key    = (start_during && c == 4) ? decoy : k;
      tick();
    end
    start = 1'b0;
    rd_en = 1'b0;
    check_eq($sformatf("%s_busy_cycles", tag), 128'(busy_cnt), 128'(10));
    check_eq($sformatf("%s_done_cycle", tag), 128'(done_cyc), 128'(11));
    check_eq($sformatf("%s_done_pulses", tag), 128'(done_cnt), 128'(1));
    check_eq($sformatf("%s_kv_cycle", tag), 128'(kv_cyc), 128'(11));
    check_eq($sformatf("%s_kv_end", tag), 128'(key_valid), 128'(1));
  endtask

  initial begin
    zero_rk[0]  = 128'h00000000000000000000000000000000;
    zero_rk[1]  = 128'h62636363626363636263636362636363;
    zero_rk[2]  = 128'h9b9898c9f9fbfbaa9b9898c9f9fbfbaa;
    zero_rk[10] = 128'hb4ef5bcb3e92e21123e951cf6f8f188e;

    fips_rk[0]  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    fips_rk[1]  = 128'ha0fafe1788542cb123a339392a6c7605;
    fips_rk[2]  = 128'hf2c295f27a96b9435935807a7359f67f;
    fips_rk[3]  = 128'h3d80477d4716fe3e1e237e446d7a883b;
    fips_rk[4]  = 128'hef44a541a8525b7fb671253bdb0bad00;
    fips_rk[5]  = 128'hd4d1c6f87c839d87caf2b8bc11f915bc;
    fips_rk[6]  = 128'h6d88a37a110b3efddbf98641ca0093fd;
    fips_rk[7]  = 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f;
    fips_rk[8]  = 128'head27321b58dbad2312bf5607f8d292f;
    fips_rk[9]  = 128'hac7766f319fadc2128d12941575c006e;
    fips_rk[10] = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;

    rst = 1'b1; start = 1'b0; key = '0; rd_en = 1'b0; rd_idx = 4'd0;
    tick();
    tick();
    rst = 1'b0;
    check_eq("rst_start_ready", 128'(start_ready), 128'(1));
    check_eq("rst_busy", 128'(busy), 128'(0));
    check_eq("rst_done", 128'(done), 128'(0));
    check_eq("rst_key_valid", 128'(key_valid), 128'(0));
    check_eq("rst_rd_valid", 128'(rd_valid), 128'(0));
    check_eq("rst_rd_data", rd_data, 128'(0));
    read_bad(4'd0, "idle_rd");

    // all-zero key
    run_expand(128'h0, 1'b0, 128'h0, 1'b0, 1'b0, 128'h0, "zero");
    read_chk(4'd0,  zero_rk[0],  "zero_rk0");
    read_chk(4'd1,  zero_rk[1],  "zero_rk1");
    read_chk(4'd2,  zero_rk[2],  "zero_rk2");
    read_chk(4'd10, zero_rk[10], "zero_rk10");

    // restart from READY with a same-cycle read of the old schedule,
    // and reads throughout the expansion
    run_expand(fips_rk[0], 1'b1, zero_rk[10], 1'b1, 1'b0, 128'h0, "fips");
    read_chk(4'd1,  fips_rk[1],  "fips_rk1");
    read_chk(4'd9,  fips_rk[9],  "fips_rk9");
    read_chk(4'd10, fips_rk[10], "fips_rk10");

    // reverse-order burst, one read per cycle
    rd_en = 1'b1;
    for (int i = 10; i >= 0; i--) begin
      rd_idx = 4'(i);
      tick();
      check_eq($sformatf("burst%0d_valid", i), 128'(rd_valid), 128'(1));
      check_eq($sformatf("burst%0d_data", i), rd_data, fips_rk[i]);
    end
    rd_en = 1'b0;
    tick();
    check_eq("burst_end_valid", 128'(rd_valid), 128'(0));

    read_bad(4'd11, "idx11");
    read_bad(4'd15, "idx15");

    // start during EXPAND at T+4 with a different key is ignored
    run_expand(fips_rk[0], 1'b0, 128'h0, 1'b0, 1'b1, 128'h0, "ign");
    read_chk(4'd5,  fips_rk[5],  "ign_rk5");
    read_chk(4'd10, fips_rk[10], "ign_rk10");

    // reset at T+5 aborts the run; new start right after
    key = fips_rk[3];
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int c = 1; c < 5; c++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_eq("abort_busy", 128'(busy), 128'(0));
    check_eq("abort_key_valid", 128'(key_valid), 128'(0));
    check_eq("abort_done", 128'(done), 128'(0));
    check_eq("abort_start_ready", 128'(start_ready), 128'(1));
    run_expand(128'h0, 1'b0, 128'h0, 1'b0, 1'b0, 128'h0, "post_abort");
    read_chk(4'd10, zero_rk[10], "post_abort_rk10");
    read_chk(4'd1,  zero_rk[1],  "post_abort_rk1");

    // rst and start together: reset wins
    rst = 1'b1;
    start = 1'b1;
    key = fips_rk[0];
    tick();
    rst = 1'b0;
    start = 1'b0;
    check_eq("rst_win_busy", 128'(busy), 128'(0));
    check_eq("rst_win_key_valid", 128'(key_valid), 128'(0));
    tick();
    check_eq("rst_win_idle_busy", 128'(busy), 128'(0));
    check_eq("rst_win_idle_ready", 128'(start_ready), 128'(1));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
